ws2812_strip: RTL and testbench

Parametrised multi-pixel WS2812 strip driver. Holds a LED_COUNT-deep pixel buffer written from the system side, and serialises the whole buffer on `dout` on each `start` request. Bit timing is derived from the clock frequency and nanosecond parameters, and every frame ends with a latch (reset) gap. It replaces the fixed single-pattern WS2812 driver in the peripheral tree and is driven by the cartridge register interface.

---
 rtl/ws2812_strip.sv | 156 +++++++++++++++
 tb/tb_ws2812_strip.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_strip.sv
// Multi-pixel WS2812 strip driver: buffers LED_COUNT {G,R,B} pixels and streams them on dout per start.
// Define WS2812_AUTO_REFRESH_EN to retransmit the buffer continuously once started.
module ws2812_strip #(
    parameter int CLK_FRE   = 21_000_000,
    parameter int LED_COUNT = 8,
    parameter int T0H_NS    = 400,
    parameter int T0L_NS    = 850,
    parameter int T1H_NS    = 850,
    parameter int T1L_NS    = 400,
    parameter int RESET_US  = 80,
    localparam int AW       = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          dout
);

    localparam logic [31:0] T0H_C = 32'((CLK_FRE / 1000 * T0H_NS) / 1_000_000);
    localparam logic [31:0] T0L_C = 32'((CLK_FRE / 1000 * T0L_NS) / 1_000_000);
    localparam logic [31:0] T1H_C = 32'((CLK_FRE / 1000 * T1H_NS) / 1_000_000);
    localparam logic [31:0] T1L_C = 32'((CLK_FRE / 1000 * T1L_NS) / 1_000_000);
    localparam logic [31:0] RST_C = 32'((CLK_FRE / 1_000_000) * RESET_US);
    localparam logic [31:0] LED_COUNT_W = 32'(LED_COUNT);
    localparam logic [AW-1:0] LAST_PIX = AW'(LED_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bitIdx_q, bitIdx_d;
    logic [AW-1:0] pix_q, pix_d;

    logic [23:0]   pixBuf [LED_COUNT];
    logic [31:0]   highLen;
    logic [31:0]   lowLen;
    logic [AW-1:0] nextPix;
    logic          latchEnd;

    assign highLen  = shift_q[23] ? T1H_C : T0H_C;
    assign lowLen   = shift_q[23] ? T1L_C : T0L_C;
    assign nextPix  = pix_q + AW'(1);
    assign latchEnd = (state_q == LATCH) && (timer_q == RST_C - 32'd1);

    // Buffer is not reset so the strip contents survive a driver reset.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < LED_COUNT_W)) begin
            pixBuf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            shift_q  <= '0;
            bitIdx_q <= '0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_d;
            pix_q    <= pix_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        shift_d  = shift_q;
        bitIdx_d = bitIdx_q;
        pix_d    = pix_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d  = pixBuf[0];
                    bitIdx_d = 5'd23;
                    pix_d    = '0;
                    timer_d  = '0;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (timer_q == highLen - 32'd1) begin
                    timer_d = '0;
                    state_d = LOW;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            LOW: begin
                if (timer_q == lowLen - 32'd1) begin
                    timer_d = '0;
                    if (bitIdx_q != 5'd0) begin
                        shift_d  = {shift_q[22:0], 1'b0};
                        bitIdx_d = bitIdx_q - 5'd1;
                        state_d  = HIGH;
                    end else if (pix_q != LAST_PIX) begin
                        // Next pixel is sampled only now, so late writes to it still go out.
                        pix_d    = nextPix;
                        shift_d  = pixBuf[nextPix];
                        bitIdx_d = 5'd23;
                        state_d  = HIGH;
                    end else begin
                        state_d = LATCH;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            LATCH: begin
                if (latchEnd) begin
                    timer_d = '0;
`ifdef WS2812_AUTO_REFRESH_EN
                    shift_d  = pixBuf[0];
                    bitIdx_d = 5'd23;
                    pix_d    = '0;
                    state_d  = HIGH;
`else
                    state_d  = IDLE;
`endif
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done marks the final latch cycle; in single-shot mode busy drops in that same cycle.
    always_comb begin
        dout = 1'b0;
        done = 1'b0;
        busy = 1'b0;
        dout = (state_q == HIGH);
        done = latchEnd;
`ifdef WS2812_AUTO_REFRESH_EN
        busy = (state_q != IDLE);
`else
        busy = (state_q != IDLE) && !latchEnd;
`endif
    end

endmodule

// File: tb/tb_ws2812_strip.sv
// Scoreboard bench for ws2812_strip with LED_COUNT=3: expected bits are queued at start and
// matched against pulse widths decoded from dout.
module tb_ws2812_strip;

   localparam int LED_COUNT = 3;
   localparam int BIT_CYC   = 25;
   localparam int LATCH_CYC = 1680;
   localparam int FRAME_CYC = LED_COUNT * 24 * BIT_CYC + LATCH_CYC;
`ifdef WS2812_AUTO_REFRESH_EN
   localparam logic EXP_BUSY_AT_DONE = 1'b1;
`else
   localparam logic EXP_BUSY_AT_DONE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [23:0] wr_data;
   logic        start;
   logic        busy;
   logic        done;
   logic        dout;

   int checkCount = 0;
   int errorCount = 0;
   int doneCount  = 0;
   int hiCnt      = 0;
   int loCnt      = 0;
   int frameCyc   = 0;
   int savedDone;
   bit expQ[$];

   ws2812_strip #(.LED_COUNT(LED_COUNT)) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .start(start),
      .busy(busy),
      .done(done),
      .dout(dout)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Queue the 24 bits of one pixel, MSB first, as the line should carry them.
   task automatic pushPixel(input logic [23:0] px);
      for (int i = 23; i >= 0; i--) expQ.push_back(px[i]);
   endtask

   // Pop the next expected bit and compare the measured high/low widths against it.
   task automatic finishBit(input bit lastBit);
      bit b;
      if (expQ.size() == 0) begin
         checkOutput("unexpectedBit", 1, 0);
      end else begin
         b = expQ.pop_front();
         checkOutput("bitHigh", hiCnt, b ? 17 : 8);
         checkOutput("bitLow", loCnt, (b ? 8 : 17) + (lastBit ? LATCH_CYC : 0));
      end
   endtask

   // Decode dout at negedges: a rising edge closes the previous bit, done closes the last bit of a frame.
   always @(negedge clk) begin
      if (rst) begin
         hiCnt    = 0;
         loCnt    = 0;
         frameCyc = 0;
      end else begin
         if (busy || done) frameCyc++;
         if (dout) begin
            if (loCnt != 0) begin
               finishBit(1'b0);
               hiCnt = 0;
               loCnt = 0;
            end
            hiCnt++;
         end else if (hiCnt != 0) begin
            loCnt++;
         end
         if (done) begin
            doneCount++;
            checkOutput("busyAtDone", busy, EXP_BUSY_AT_DONE);
            checkOutput("frameLen", frameCyc, FRAME_CYC);
            frameCyc = 0;
            if (hiCnt != 0) finishBit(1'b1);
            else checkOutput("doneWithoutBits", 0, 1);
            hiCnt = 0;
            loCnt = 0;
         end
      end
   end

   task automatic writePixel(input logic [1:0] addr, input logic [23:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Pulse start for one cycle and confirm the line goes high right after the sampling edge.
   task automatic applyStimulus();
      start = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("startDout", dout, 1);
      checkOutput("startBusy", busy, 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int startDone;
      int n;
      startDone = doneCount;
      n = 0;
      while (doneCount == startDone && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (doneCount == startDone) checkOutput("doneTimeout", 0, 1);
   endtask

   task automatic resetPulse();
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstDout", dout, 0);
      checkOutput("rstBusy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetDout", dout, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      rst = 1'b0;
      @(negedge clk);

`ifdef WS2812_AUTO_REFRESH_EN
      writePixel(2'd0, 24'h800001);
      writePixel(2'd1, 24'h00FF00);
      writePixel(2'd2, 24'hFFFFFF);
      for (int f = 0; f < 4; f++) begin
         pushPixel(24'h800001);
         pushPixel(24'h00FF00);
         pushPixel(24'hFFFFFF);
      end
      applyStimulus();
      for (int f = 0; f < 3; f++) begin
         waitDone(FRAME_CYC + 100);
         checkOutput("autoBusy", busy, 1);
      end
      checkOutput("autoDoneCount", doneCount, 3);
      resetPulse();
      repeat (100) @(negedge clk);
      checkOutput("autoStopped", busy, 0);
`else
      // Multi-pixel frame with distinct patterns across the pixel boundaries.
      writePixel(2'd0, 24'h800001);
      writePixel(2'd1, 24'h000000);
      writePixel(2'd2, 24'hFFFFFF);
      pushPixel(24'h800001);
      pushPixel(24'h000000);
      pushPixel(24'hFFFFFF);
      applyStimulus();
      waitDone(FRAME_CYC + 100);
      checkOutput("doneCount1", doneCount, 1);

      // Writes during pixel 0: pixel 2 is still pending, pixel 0 is already loaded.
      writePixel(2'd0, 24'h00FF00);
      writePixel(2'd1, 24'h123456);
      writePixel(2'd2, 24'h800001);
      pushPixel(24'h00FF00);
      pushPixel(24'h123456);
      pushPixel(24'hAAAAAA);
      applyStimulus();
      repeat (5 * BIT_CYC) @(negedge clk);
      writePixel(2'd2, 24'hAAAAAA);
      writePixel(2'd0, 24'h654321);
      writePixel(2'd3, 24'h000000);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      waitDone(FRAME_CYC + 100);
      repeat (50) @(negedge clk);
      checkOutput("doneCount2", doneCount, 2);
      checkOutput("idleAfterFrame", busy, 0);
      checkOutput("queueDrained", expQ.size(), 0);

      // Next frame carries the late pixel 0 write.
      pushPixel(24'h654321);
      pushPixel(24'h123456);
      pushPixel(24'hAAAAAA);
      applyStimulus();
      waitDone(FRAME_CYC + 100);
      checkOutput("doneCount3", doneCount, 3);

      // Reset around bit 10 abandons the frame without a done pulse.
      pushPixel(24'h654321);
      pushPixel(24'h123456);
      pushPixel(24'hAAAAAA);
      applyStimulus();
      repeat (10 * BIT_CYC - 2) @(negedge clk);
      resetPulse();
      savedDone = doneCount;
      repeat (2000) @(negedge clk);
      checkOutput("noDoneAfterRst", doneCount, savedDone);
      checkOutput("idleAfterRst", busy, 0);
      checkOutput("lowAfterRst", dout, 0);

      pushPixel(24'h654321);
      pushPixel(24'h123456);
      pushPixel(24'hAAAAAA);
      applyStimulus();
      waitDone(FRAME_CYC + 100);
      checkOutput("doneCount4", doneCount, 4);
      checkOutput("queueEmpty", expQ.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
